// File: rtl/traffic_generator_gmii_axil_master.sv
// traffic_generator_gmii_axil_master: single-outstanding AXI4-Lite master, one command -> one transaction (rev 1.0).
// Optional transaction counters (wr_count/rd_count/err_count) are built when AXIL_MASTER_STATS_EN is defined.
`default_nettype none

module traffic_generator_gmii_axil_master #(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 12,
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
`ifdef AXIL_MASTER_STATS_EN
  output logic [31:0]                       wr_count,
  output logic [31:0]                       rd_count,
  output logic [31:0]                       err_count,
`endif
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = C_BASE_ADDRESS[C_M_AXI_ADDR_WIDTH-1:0];

  logic [2:0] state;
  logic [2:0] state_next;
  logic       aw_done;
  logic       w_done;
  logic       cmd_hs;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;
  logic       r_hs;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID & M_AXI_BREADY;
  assign r_hs   = M_AXI_RVALID & M_AXI_RREADY;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= S_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cmd_hs) state_next = cmd_write ? S_WR : S_RD_ADDR;
      // A handshake in this cycle counts as done so coincident AW/W handshakes leave WR at once
      S_WR:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = S_WR_RESP;
      S_WR_RESP: if (b_hs) state_next = S_RSP;
      S_RD_ADDR: if (M_AXI_ARVALID & M_AXI_ARREADY) state_next = S_RD_DATA;
      S_RD_DATA: if (r_hs) state_next = S_RSP;
      S_RSP:     if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Every handshake output is decoded from flops only, so no input reaches an output combinationally
  always_comb begin
    cmd_ready     = (state == S_IDLE);
    busy          = (state != S_IDLE);
    M_AXI_AWVALID = (state == S_WR) & ~aw_done;
    M_AXI_WVALID  = (state == S_WR) & ~w_done;
    M_AXI_BREADY  = (state == S_WR_RESP);
    M_AXI_ARVALID = (state == S_RD_ADDR);
    M_AXI_RREADY  = (state == S_RD_DATA);
    rsp_valid     = (state == S_RSP);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      M_AXI_AWADDR <= '0;
      M_AXI_WDATA  <= '0;
      M_AXI_WSTRB  <= '0;
      M_AXI_ARADDR <= '0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
    end else begin
      if (cmd_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cmd_write) begin
          M_AXI_AWADDR <= cmd_addr ^ BASE_ADDR;
          M_AXI_WDATA  <= cmd_wdata;
          M_AXI_WSTRB  <= cmd_wstrb;
        end else begin
          M_AXI_ARADDR <= cmd_addr ^ BASE_ADDR;
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_BRESP;
      end
      if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp  <= M_AXI_RRESP;
      end
    end
  end

`ifdef AXIL_MASTER_STATS_EN
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      if (b_hs) wr_count <= wr_count + 32'd1;
      if (r_hs) rd_count <= rd_count + 32'd1;
      if ((b_hs && M_AXI_BRESP != 2'b00) || (r_hs && M_AXI_RRESP != 2'b00))
        err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_traffic_generator_gmii_axil_master.sv
// Directed self-checking bench for traffic_generator_gmii_axil_master with a latency-configurable AXI4-Lite slave.
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_generator_gmii_axil_master;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_ready = 1'b1;
  logic          cmd_ready, rsp_valid, rsp_write, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
`ifdef AXIL_MASTER_STATS_EN
  logic [31:0]   wr_count, rd_count, err_count;
`endif
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  // slave configuration: READY/VALID asserted in the lat-th cycle the master's signal is seen
  int            aw_lat = 2, w_lat = 2, b_lat = 1, ar_lat = 2, r_lat = 1;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  int aw_vcyc = 0, w_vcyc = 0, b_hs_cnt = 0, r_hs_cnt = 0, rsp_cnt = 0;
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] wd_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  traffic_generator_gmii_axil_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
`ifdef AXIL_MASTER_STATS_EN
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
`endif
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave and monitor act on the falling edge, halfway between DUT updates
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
    end else begin
      if (awvalid) begin
        awready <= (aw_c + 1 >= aw_lat); aw_c <= aw_c + 1; aw_vcyc <= aw_vcyc + 1;
        if (aw_c + 1 >= aw_lat) aw_q.push_back(awaddr);
      end else begin awready <= 1'b0; aw_c <= 0; end
      if (wvalid) begin
        wready <= (w_c + 1 >= w_lat); w_c <= w_c + 1; w_vcyc <= w_vcyc + 1;
        if (w_c + 1 >= w_lat) wd_q.push_back(wdata);
      end else begin wready <= 1'b0; w_c <= 0; end
      if (bready) begin
        bvalid <= (b_c + 1 >= b_lat); b_c <= b_c + 1; bresp <= bresp_cfg;
        if (b_c + 1 >= b_lat) b_hs_cnt <= b_hs_cnt + 1;
      end else begin bvalid <= 1'b0; b_c <= 0; end
      if (arvalid) begin arready <= (ar_c + 1 >= ar_lat); ar_c <= ar_c + 1; end
      else begin arready <= 1'b0; ar_c <= 0; end
      if (rready) begin
        rvalid <= (r_c + 1 >= r_lat); r_c <= r_c + 1; rdata <= rdata_cfg; rresp <= rresp_cfg;
        if (r_c + 1 >= r_lat) r_hs_cnt <= r_hs_cnt + 1;
      end else begin rvalid <= 1'b0; r_c <= 0; end
      if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end
  end

  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, output int acc);
    acc = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 12'hFFC; cmd_wdata = 32'hBAD0_BAD0; cmd_wstrb = 4'h0;
    n_cmp++;
    if (acc < 0) begin n_fail++; $display("FAIL cmd_accept_timeout: cmd_ready never seen within 50 cycles"); end
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rsp_valid) begin rc = cyc; break; end
    end
    n_cmp++;
    if (rc < 0) begin n_fail++; $display("FAIL rsp_timeout: rsp_valid never seen within 60 cycles"); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_axi_handshakes: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: awaddr=%h araddr=%h wdata=%h wstrb=%h want all 0", awaddr, araddr, wdata, wstrb); end
    n_cmp++; if ({rsp_write, rsp_rdata, rsp_resp} !== '0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got %b/%h/%b want 0/0/00", rsp_write, rsp_rdata, rsp_resp); end
`ifdef AXIL_MASTER_STATS_EN
    n_cmp++; if ({wr_count, rd_count, err_count} !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", wr_count, rd_count, err_count); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write;
    int acc, rc;
    aw_lat = 2; w_lat = 2; b_lat = 1; bresp_cfg = 2'b00;
    issue_cmd(1'b1, 12'h010, 32'h0000_0040, 4'hF, acc);
    @(negedge clk);
    n_cmp++; if (cyc - acc !== 1 || awvalid !== 1'b1 || wvalid !== 1'b1) begin
      n_fail++; $display("FAIL wr_valid_n1: cyc+%0d awvalid=%b wvalid=%b want +1/1/1", cyc - acc, awvalid, wvalid); end
    n_cmp++; if (awaddr !== 12'h010 || wdata !== 32'h40 || wstrb !== 4'hF) begin
      n_fail++; $display("FAIL wr_addr_data: got %h/%h/%h want 010/00000040/f", awaddr, wdata, wstrb); end
    wait_rsp(rc);
    n_cmp++; if (rc - acc !== 4) begin n_fail++; $display("FAIL wr_latency: got N+%0d want N+4", rc - acc); end
    n_cmp++; if (rsp_write !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wr_rsp: got write=%b resp=%b rdata=%h want 1/00/0", rsp_write, rsp_resp, rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_return_idle: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read;
    int acc, rc;
    ar_lat = 2; r_lat = 1; rresp_cfg = 2'b00; rdata_cfg = 32'hDEAD_BEEF;
    issue_cmd(1'b0, 12'h000, 32'h1111_1111, 4'h3, acc);
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1 || araddr !== 12'h000 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_ar: arvalid=%b araddr=%h awvalid=%b want 1/000/0", arvalid, araddr, awvalid); end
    wait_rsp(rc);
    n_cmp++; if (rc - acc !== 4) begin n_fail++; $display("FAIL rd_latency: got N+%0d want N+4", rc - acc); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_write !== 1'b0 || rsp_resp !== 2'b00) begin
      n_fail++; $display("FAIL rd_rsp: got %h/%b/%b want deadbeef/0/00", rsp_rdata, rsp_write, rsp_resp); end
    @(negedge clk);
  endtask

  task automatic test_delayed_aw;
    int acc, rc, aw0, w0, b0, r0;
    aw_lat = 3; w_lat = 1; b_lat = 1;
    aw0 = aw_vcyc; w0 = w_vcyc; b0 = b_hs_cnt; r0 = rsp_cnt;
    issue_cmd(1'b1, 12'h020, 32'hCAFE_0001, 4'h5, acc);
    wait_rsp(rc);
    repeat (4) @(negedge clk);
    n_cmp++; if (aw_vcyc - aw0 !== 3) begin n_fail++; $display("FAIL dly_awvalid_cycles: got %0d want 3", aw_vcyc - aw0); end
    n_cmp++; if (w_vcyc - w0 !== 1) begin n_fail++; $display("FAIL dly_wvalid_cycles: got %0d want 1", w_vcyc - w0); end
    n_cmp++; if (b_hs_cnt - b0 !== 1) begin n_fail++; $display("FAIL dly_b_handshakes: got %0d want 1", b_hs_cnt - b0); end
    n_cmp++; if (rsp_cnt - r0 !== 1) begin n_fail++; $display("FAIL dly_responses: got %0d want 1", rsp_cnt - r0); end
  endtask

  task automatic test_err_backpressure;
    int acc, rc;
    ar_lat = 2; r_lat = 1; rresp_cfg = 2'b10; rdata_cfg = 32'h0BAD_F00D;
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 12'h004, 32'h0, 4'h0, acc);
    wait_rsp(rc);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL err_hold_c%0d: rsp_valid=%b resp=%b cmd_ready=%b want 1/10/0", k, rsp_valid, rsp_resp, cmd_ready); end
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_release: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
`ifdef AXIL_MASTER_STATS_EN
    n_cmp++; if (err_count !== 32'd1 || rd_count !== 32'd2 || wr_count !== 32'd2) begin
      n_fail++; $display("FAIL err_counters: wr/rd/err got %0d/%0d/%0d want 2/2/1", wr_count, rd_count, err_count); end
`endif
    rresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid;
    int acc, rc, n;
    bit seen, saw_rsp;
    aw_lat = 1; w_lat = 1; b_lat = 50;
    issue_cmd(1'b1, 12'h030, 32'h7777_7777, 4'hF, acc);
    seen = 1'b0;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (bready) begin seen = 1'b1; break; end end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_wr_resp: bready never seen"); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (bready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async_drop: bready=%b busy=%b rsp_valid=%b cmd_ready=%b want 0/0/0/1", bready, busy, rsp_valid, cmd_ready); end
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    b_lat = 1; aw_lat = 2; w_lat = 2;
    saw_rsp = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
    n_cmp++; if (saw_rsp) begin n_fail++; $display("FAIL rstmid_discard: rsp_valid got 1 want 0 after reset"); end
    issue_cmd(1'b1, 12'h004, 32'h1234_5678, 4'hF, acc);
    wait_rsp(rc);
    n_cmp++; if (rc - acc !== 4 || rsp_write !== 1'b1 || rsp_resp !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_next_cmd: latency N+%0d write=%b resp=%b want N+4/1/00", rc - acc, rsp_write, rsp_resp); end
    n_cmp++; if (aw_q.size() == 0 || aw_q[aw_q.size()-1] !== 12'h004) begin
      n_fail++; $display("FAIL rstmid_next_addr: got %h want 004", aw_q.size() ? aw_q[aw_q.size()-1] : 12'hXXX); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int q0, r0, b0, n;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    aw_lat = 1; w_lat = 2; b_lat = 1;
    q0 = aw_q.size(); r0 = rsp_cnt; b0 = b_hs_cnt;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wstrb = 4'hF;
    for (int i = 0; i < 100; i++) begin
      cmd_addr = 12'(i * 4); cmd_wdata = 32'hA500_0000 + 32'(i);
      for (n = 0; n < 50; n++) begin @(negedge clk); if (cmd_ready) break; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (n = 0; n < 200; n++) begin @(negedge clk); if (rsp_cnt - r0 >= 100 && !busy) break; end
    @(negedge clk);
    n_cmp++; if (rsp_cnt - r0 !== 100) begin n_fail++; $display("FAIL b2b_responses: got %0d want 100", rsp_cnt - r0); end
    n_cmp++; if (b_hs_cnt - b0 !== 100) begin n_fail++; $display("FAIL b2b_b_handshakes: got %0d want 100", b_hs_cnt - b0); end
    for (int i = 0; i < 100; i++) begin
      n_cmp++;
      if (q0 + i >= aw_q.size() || aw_q[q0+i] !== 12'(i * 4) || wd_q[q0+i] !== 32'hA500_0000 + 32'(i)) begin
        n_fail++; $display("FAIL b2b_order_%0d: addr/data out of order or missing, want %h/%h", i, 12'(i * 4), 32'hA500_0000 + 32'(i));
      end
    end
`ifdef AXIL_MASTER_STATS_EN
    n_cmp++; if (wr_count !== 32'd100 || err_count !== 32'd0) begin
      n_fail++; $display("FAIL b2b_wr_count: wr=%0d err=%0d want 100/0", wr_count, err_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_delayed_aw();
    test_err_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
